vehicle_sensor_interface: RTL and testbench

Front-end that produces the street request inputs sa/sb consumed by the traffic light controller. Per street it synchronizes and debounces a raw loop-detector signal, counts arriving cars, and retires queued cars while that street's green (ga/gb, fed back from the controller) is on. sa/sb assert whenever a street's queue is non-empty.

---
 rtl/vehicle_sensor_interface.sv | 155 +++++++++++++++
 tb/tb_vehicle_sensor_interface.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_sensor_interface.sv
// Per-street detector synchronizer, debouncer and car queue feeding the traffic light controller.
// Define SENSOR_FAULT_EN to add stuck-detector fault outputs fault_a/fault_b.
module vehicle_sensor_interface #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PASS_CYCLES     = 3,
  parameter int COUNT_W         = 4,
  parameter int FAULT_CYCLES    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               det_a,
  input  logic               det_b,
  input  logic               ga,
  input  logic               gb,
  output logic               sa,
  output logic               sb,
  output logic [COUNT_W-1:0] count_a,
  output logic [COUNT_W-1:0] count_b,
  output logic               ovf_a,
  output logic               ovf_b
`ifdef SENSOR_FAULT_EN
  ,
  output logic               fault_a,
  output logic               fault_b
`endif
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PT_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PT_W-1:0]    PT_LAST = PT_W'(PASS_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // Index 0 is street A, index 1 is street B.
  logic [1:0] det, green;
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] filt_q, filt_d, ovf_q, ovf_d;
  logic [1:0] arrive, depart;
  logic [DB_W-1:0]    db_cnt_q [2];
  logic [DB_W-1:0]    db_cnt_d [2];
  logic [PT_W-1:0]    pt_q     [2];
  logic [PT_W-1:0]    pt_d     [2];
  logic [COUNT_W-1:0] cnt_q    [2];
  logic [COUNT_W-1:0] cnt_d    [2];

`ifdef SENSOR_FAULT_EN
  localparam int FLT_W = $clog2(FAULT_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FAULT_CYCLES - 1);
  logic [FLT_W-1:0] stuck_q [2];
  logic [FLT_W-1:0] stuck_d [2];
  logic [1:0]       fault_q, fault_d;
`endif

  assign det   = {det_b, det_a};
  assign green = {gb, ga};

  always_comb begin
    sync1_d = det;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    ovf_d   = ovf_q;
    arrive  = '0;
    depart  = '0;
`ifdef SENSOR_FAULT_EN
    fault_d = fault_q;
`endif
    for (int s = 0; s < 2; s++) begin
      db_cnt_d[s] = db_cnt_q[s];
      pt_d[s]     = '0;
      cnt_d[s]    = cnt_q[s];

      // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
      if (sync2_q[s] == filt_q[s]) begin
        db_cnt_d[s] = '0;
      end else if (db_cnt_q[s] == DB_LAST) begin
        filt_d[s]   = sync2_q[s];
        db_cnt_d[s] = '0;
        arrive[s]   = sync2_q[s];
      end else begin
        db_cnt_d[s] = db_cnt_q[s] + DB_W'(1);
      end

`ifdef SENSOR_FAULT_EN
      stuck_d[s] = '0;
      if (filt_q[s] && !fault_q[s]) begin
        if (stuck_q[s] == FLT_LAST) fault_d[s] = 1'b1;
        else                        stuck_d[s] = stuck_q[s] + FLT_W'(1);
      end
      if (fault_q[s]) arrive[s] = 1'b0;
`endif

      // Green time only accumulates while cars are queued; any gap restarts the interval.
      if (green[s] && (cnt_q[s] != '0)) begin
        if (pt_q[s] == PT_LAST) depart[s] = 1'b1;
        else                    pt_d[s]   = pt_q[s] + PT_W'(1);
      end

      if (arrive[s] && !depart[s]) begin
        if (cnt_q[s] == CNT_MAX) ovf_d[s] = 1'b1;
        else                     cnt_d[s] = cnt_q[s] + COUNT_W'(1);
      end else if (depart[s] && !arrive[s]) begin
        cnt_d[s] = cnt_q[s] - COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      ovf_q   <= '0;
      for (int s = 0; s < 2; s++) begin
        db_cnt_q[s] <= '0;
        pt_q[s]     <= '0;
        cnt_q[s]    <= '0;
      end
`ifdef SENSOR_FAULT_EN
      fault_q <= '0;
      for (int s = 0; s < 2; s++) stuck_q[s] <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      ovf_q   <= ovf_d;
      for (int s = 0; s < 2; s++) begin
        db_cnt_q[s] <= db_cnt_d[s];
        pt_q[s]     <= pt_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
`ifdef SENSOR_FAULT_EN
      fault_q <= fault_d;
      for (int s = 0; s < 2; s++) stuck_q[s] <= stuck_d[s];
`endif
    end
  end

  assign count_a = cnt_q[0];
  assign count_b = cnt_q[1];
  assign ovf_a   = ovf_q[0];
  assign ovf_b   = ovf_q[1];

`ifdef SENSOR_FAULT_EN
  // A stuck loop keeps requesting green so the street is never starved.
  assign sa      = (cnt_q[0] != '0) | fault_q[0];
  assign sb      = (cnt_q[1] != '0) | fault_q[1];
  assign fault_a = fault_q[0];
  assign fault_b = fault_q[1];
`else
  assign sa = (cnt_q[0] != '0);
  assign sb = (cnt_q[1] != '0);
`endif

endmodule

// File: tb/tb_vehicle_sensor_interface.sv
// Directed bench for vehicle_sensor_interface with a cycle-level reference model.
// Define SENSOR_FAULT_EN to also exercise the stuck-detector fault outputs.
module tb_vehicle_sensor_interface;

  localparam int DEB  = 4;
  localparam int PAS  = 3;
  localparam int CW   = 4;
  localparam int FLT  = 64;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [31:0] WMASK = (32'd1 << DEB) - 32'd1;

  logic clk, reset, det_a, det_b, ga, gb;
  logic sa, sb, ovf_a, ovf_b;
  logic [CW-1:0] count_a, count_b;
`ifdef SENSOR_FAULT_EN
  logic fault_a, fault_b;
`endif

  int checks = 0;
  int errors = 0;

  vehicle_sensor_interface #(
    .DEBOUNCE_CYCLES(DEB),
    .PASS_CYCLES(PAS),
    .COUNT_W(CW),
    .FAULT_CYCLES(FLT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .det_a(det_a),
    .det_b(det_b),
    .ga(ga),
    .gb(gb),
    .sa(sa),
    .sb(sb),
    .count_a(count_a),
    .count_b(count_b),
    .ovf_a(ovf_a),
    .ovf_b(ovf_b)
`ifdef SENSOR_FAULT_EN
    ,
    .fault_a(fault_a),
    .fault_b(fault_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic car(input int street);
    if (street == 0) det_a = 1'b1; else det_b = 1'b1;
    tick(6);
    if (street == 0) det_a = 1'b0; else det_b = 1'b0;
    tick(6);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  // Reference model: a filtered level flips once the last DEB synchronized samples
  // all disagree with it; a car leaves after PAS unbroken cycles of useful green.
  logic [1:0] m_s1, m_s2, m_filt, m_ovf, m_fault, m_det, m_g;
  logic [31:0] m_hist [2];
  int m_cnt [2];
  int m_grun [2];
  int m_hrun [2];
  logic m_arr, m_dep, m_oldfault;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        m_s1[s] = 0; m_s2[s] = 0; m_filt[s] = 0; m_ovf[s] = 0; m_fault[s] = 0;
        m_hist[s] = 0; m_cnt[s] = 0; m_grun[s] = 0; m_hrun[s] = 0;
      end
    end else begin
      m_det = {det_b, det_a};
      m_g   = {gb, ga};
      for (int s = 0; s < 2; s++) begin
        m_arr = 0;
        m_dep = 0;
        m_oldfault = m_fault[s];
`ifdef SENSOR_FAULT_EN
        if (m_filt[s]) m_hrun[s]++; else m_hrun[s] = 0;
        if (m_hrun[s] >= FLT) m_fault[s] = 1;
`endif
        m_hist[s] = {m_hist[s][30:0], m_s2[s]};
        if ((m_hist[s] & WMASK) == (m_filt[s] ? 32'd0 : WMASK)) begin
          m_arr = !m_filt[s];
          m_filt[s] = !m_filt[s];
        end
        if (m_oldfault) m_arr = 0;
        if (m_g[s] && m_cnt[s] != 0) begin
          m_grun[s]++;
          if (m_grun[s] == PAS) begin
            m_dep = 1;
            m_grun[s] = 0;
          end
        end else begin
          m_grun[s] = 0;
        end
        if (m_arr && !m_dep) begin
          if (m_cnt[s] == MAXC) m_ovf[s] = 1; else m_cnt[s]++;
        end else if (m_dep && !m_arr) begin
          m_cnt[s]--;
        end
        m_s2[s] = m_s1[s];
        m_s1[s] = m_det[s];
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_count_a", count_a, m_cnt[0]);
      chk("model_count_b", count_b, m_cnt[1]);
      chk("model_sa", sa, (m_cnt[0] != 0 || m_fault[0]) ? 1 : 0);
      chk("model_sb", sb, (m_cnt[1] != 0 || m_fault[1]) ? 1 : 0);
      chk("model_ovf_a", ovf_a, m_ovf[0]);
      chk("model_ovf_b", ovf_b, m_ovf[1]);
`ifdef SENSOR_FAULT_EN
      chk("model_fault_a", fault_a, m_fault[0]);
      chk("model_fault_b", fault_b, m_fault[1]);
`endif
    end
  end

  initial begin
    det_a = 0; det_b = 0; ga = 0; gb = 0; reset = 0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_count_a", count_a, 0);
    chk("reset_count_b", count_b, 0);
    chk("reset_sa", sa, 0);
    chk("reset_sb", sb, 0);
    chk("reset_ovf_b", ovf_b, 0);
    tick(20);
    chk("idle_sa", sa, 0);
    chk("idle_count_b", count_b, 0);

    // Single car on A arrives six edges after det_a is raised; short B pulse is rejected.
    det_a = 1; det_b = 1;
    tick(3);
    det_b = 0;
    tick(2);
    chk("latency_before_edge6", count_a, 0);
    tick(1);
    chk("latency_edge6_count_a", count_a, 1);
    chk("latency_edge6_sa", sa, 1);
    det_a = 0;
    tick(8);
    chk("glitch_b_count_b", count_b, 0);

    // Drain two cars with continuous green.
    car(0);
    chk("two_cars_count_a", count_a, 2);
    ga = 1;
    tick(3);
    chk("drain_first", count_a, 1);
    tick(3);
    chk("drain_second", count_a, 0);
    chk("drain_sa", sa, 0);
    ga = 0;

    // A broken green interval is discarded.
    car(0);
    ga = 1; tick(2);
    ga = 0; tick(1);
    ga = 1; tick(2);
    chk("partial_green_held", count_a, 1);
    tick(1);
    chk("partial_green_depart", count_a, 0);
    ga = 0;

    // Arrival and departure on the same edge leave the count unchanged.
    car(0);
    det_a = 1;
    tick(3);
    ga = 1;
    tick(2);
    chk("simul_before", count_a, 1);
    tick(1);
    chk("simul_same_edge", count_a, 1);
    ga = 0;
    chk("simul_b_untouched", count_b, 0);
    det_a = 0;
    tick(6);
    ga = 1; tick(3); ga = 0;
    chk("simul_drained", count_a, 0);

    // Saturation on B.
    for (int i = 0; i < 15; i++) car(1);
    chk("sat15_count_b", count_b, 15);
    chk("sat15_ovf_b", ovf_b, 0);
    car(1);
    chk("sat16_count_b", count_b, 15);
    chk("sat16_ovf_b", ovf_b, 1);
    gb = 1;
    tick(48);
    gb = 0;
    chk("sat_drained_count_b", count_b, 0);
    chk("sat_drained_sb", sb, 0);
    chk("sat_sticky_ovf_b", ovf_b, 1);

    // Reset mid-operation with det_a held high.
    car(0);
    det_a = 1;
    tick(2);
    pulse_reset();
    chk("midreset_count_a", count_a, 0);
    chk("midreset_ovf_b", ovf_b, 0);
    tick(6);
    chk("after_reset_arrival", count_a, 1);
    tick(6);
    chk("after_reset_single", count_a, 1);
    det_a = 0;
    tick(6);
    ga = 1; tick(3); ga = 0;
    chk("after_reset_drained", count_a, 0);

`ifdef SENSOR_FAULT_EN
    det_a = 1;
    tick(80);
    chk("fault_set", fault_a, 1);
    chk("fault_one_car", count_a, 1);
    det_a = 0;
    tick(6);
    ga = 1; tick(3); ga = 0;
    chk("fault_count_drained", count_a, 0);
    chk("fault_sa_forced", sa, 1);
    chk("fault_sticky", fault_a, 1);
    pulse_reset();
    chk("fault_reset_clear", fault_a, 0);
    chk("fault_reset_sa", sa, 0);
    tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
